// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives imem from the current PC, queues fetched words in order for decode.
// Optional FETCH_STATS_EN adds fetch_count/stall_count performance counters.
module instr_fetch_unit #(
  parameter int QDEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] i_addr,
  output logic        pc_next,
  input  logic        redirect,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_q_instr [QDEPTH];
  logic [31:0]     r_q_pc    [QDEPTH];

  logic            w_full;
  logic            w_fetch_en;
  logic            w_redir;
  logic            w_accept;
  logic            w_pop;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (halt) r_state <= S_HALTED;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Fetch enable comes from the registered count, so a pop frees a slot only on the next cycle.
  assign w_full      = (r_count == CW'(QDEPTH));
  assign w_fetch_en  = (r_state == S_FETCH) && !w_full && !halt;
  assign w_redir     = redirect && (r_state != S_HALTED) && !halt;
  assign w_accept    = w_fetch_en && ihit && !redirect;
  assign w_pop       = instr_valid && instr_ready && !w_redir;

  assign imemaddr    = i_addr;
  assign imemREN     = nRST && w_fetch_en;
  assign pc_next     = nRST && (w_redir || w_accept);
  assign instr_valid = (r_count != '0);
  assign instr       = r_q_instr[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_redir) begin
      // Taken control flow: everything queued is on the wrong path.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_q_instr[r_wr_ptr] <= imemload;
        r_q_pc[r_wr_ptr]    <= i_addr;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (w_accept) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if ((r_state == S_FETCH) && ((w_fetch_en && !ihit) || w_full)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a queue-based behavioural model.
module tb_instr_fetch_unit;
  localparam int QD = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] i_addr;
  logic        pc_next;
  logic        redirect;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instr_fetch_unit #(.QDEPTH(QD)) dut (
    .CLK(CLK), .nRST(nRST), .i_addr(i_addr), .pc_next(pc_next),
    .redirect(redirect), .halt(halt), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  // Model: fetch queue, PC and phase (0 idle, 1 fetching, 2 halted)
  ent_t        q[$];
  int          mst;
  logic [31:0] pc;
  logic [31:0] m_fetch, m_stall;

  logic e_ren, e_pcn, e_vld;
  ent_t e_head;
  bit   p_rdv, p_acc, p_pop, p_hl, p_stall;
  logic [31:0] p_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic model_reset();
    q.delete();
    mst = 0;
    pc = 32'h0;
    m_fetch = 32'h0;
    m_stall = 32'h0;
  endtask

  task automatic apply(input bit ih, input bit rdy, input bit rd, input bit hl,
                       input logic [31:0] tgt);
    bit full;
    ihit = ih; instr_ready = rdy; redirect = rd; halt = hl;
    i_addr = pc; imemload = mem_word(pc);
    #1;
    full   = (q.size() == QD);
    e_ren  = (mst == 1) && !full && !hl;
    p_rdv  = rd && (mst != 2) && !hl;
    p_acc  = e_ren && ih && !rd;
    e_pcn  = p_rdv || p_acc;
    e_vld  = (q.size() != 0);
    e_head = e_vld ? q[0] : '0;
    p_pop  = e_vld && rdy && !p_rdv;
    p_hl   = hl;
    p_tgt  = tgt;
    p_stall = (mst == 1) && ((e_ren && !ih) || full);
  endtask

  task automatic advance();
    if (p_rdv) q.delete();
    else begin
      if (p_pop) void'(q.pop_front());
      if (p_acc) q.push_back({mem_word(pc), pc});
    end
    if (p_acc) m_fetch = m_fetch + 1;
    if (p_stall) m_stall = m_stall + 1;
    if (e_pcn) pc = p_rdv ? p_tgt : pc + 32'd4;
    if (mst == 0) mst = 1;
    else if (mst == 1 && p_hl) mst = 2;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b1; instr_ready = 1'b1; redirect = 1'b0; halt = 1'b0;
    i_addr = 32'h0; imemload = 32'hDEADBEEF;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL reset_imemREN got=%b exp=0", imemREN); end
    checks++; if (pc_next !== 1'b0) begin errors++; $display("FAIL reset_pc_next got=%b exp=0", pc_next); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
    nRST = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] seen[$];
    for (int c = 0; c < 10; c++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (instr_valid === 1'b1) seen.push_back(instr_pc);
      checks++; if (imemaddr !== pc) begin errors++; $display("FAIL stream_imemaddr cyc=%0d got=%h exp=%h", c, imemaddr, pc); end
      checks++; if (imemREN !== e_ren) begin errors++; $display("FAIL stream_imemREN cyc=%0d got=%b exp=%b", c, imemREN, e_ren); end
      checks++; if (pc_next !== e_pcn) begin errors++; $display("FAIL stream_pc_next cyc=%0d got=%b exp=%b", c, pc_next, e_pcn); end
      checks++; if (instr_valid !== e_vld) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, instr_valid, e_vld); end
      if (e_vld) begin
        checks++; if ({instr, instr_pc} !== e_head) begin errors++; $display("FAIL stream_head cyc=%0d got=%h/%h exp=%h/%h", c, instr, instr_pc, e_head.ins, e_head.pc); end
      end
      if (c >= 1) begin
        checks++; if (pc_next !== 1'b1) begin errors++; $display("FAIL stream_full_rate cyc=%0d got=%b exp=1", c, pc_next); end
      end
      advance();
    end
    checks++;
    if (seen.size() < 3 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
      errors++; $display("FAIL stream_pc_seq got_count=%0d exp=0,4,8", seen.size());
    end
  endtask

  task automatic test_wait();
    for (int c = 0; c < 16; c++) begin
      apply(c % 4 == 3, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (imemREN !== e_ren) begin errors++; $display("FAIL wait_imemREN cyc=%0d got=%b exp=%b", c, imemREN, e_ren); end
      checks++; if (pc_next !== e_pcn) begin errors++; $display("FAIL wait_pc_next cyc=%0d got=%b exp=%b", c, pc_next, e_pcn); end
      checks++; if (instr_valid !== e_vld) begin errors++; $display("FAIL wait_valid cyc=%0d got=%b exp=%b", c, instr_valid, e_vld); end
      if (e_vld) begin
        checks++; if ({instr, instr_pc} !== e_head) begin errors++; $display("FAIL wait_head cyc=%0d got=%h/%h exp=%h/%h", c, instr, instr_pc, e_head.ins, e_head.pc); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    advance();
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (imemREN !== e_ren) begin errors++; $display("FAIL bp_imemREN cyc=%0d got=%b exp=%b", c, imemREN, e_ren); end
      checks++; if (pc_next !== e_pcn) begin errors++; $display("FAIL bp_pc_next cyc=%0d got=%b exp=%b", c, pc_next, e_pcn); end
      advance();
    end
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL bp_full_ren got=%b exp=0", imemREN); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head0 got=%h exp=0", instr_pc); end
    advance();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL bp_head4 got=%h exp=4", instr_pc); end
    checks++; if (imemREN !== 1'b1 || pc_next !== 1'b1 || imemaddr !== 32'h8) begin
      errors++; $display("FAIL bp_refetch got=%b/%b/%h exp=1/1/8", imemREN, pc_next, imemaddr); end
    advance();
  endtask

  task automatic test_redirect();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h10);
    advance();
    repeat (2) begin apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); advance(); end
    apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h400);
    checks++; if (instr_pc !== 32'h10) begin errors++; $display("FAIL redir_head got=%h exp=10", instr_pc); end
    checks++; if (pc_next !== 1'b1) begin errors++; $display("FAIL redir_pc_next got=%b exp=1", pc_next); end
    advance();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", instr_valid); end
    checks++; if (imemaddr !== 32'h400) begin errors++; $display("FAIL redir_target got=%h exp=400", imemaddr); end
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin
      errors++; $display("FAIL redir_newpc got=%b/%h exp=1/400", instr_valid, instr_pc); end
    checks++; if (instr !== mem_word(32'h400)) begin errors++; $display("FAIL redir_instr got=%h exp=%h", instr, mem_word(32'h400)); end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, 1'b0, $urandom & 32'hFFFF_FFFC);
      checks++; if (imemREN !== e_ren) begin errors++; $display("FAIL rnd_imemREN cyc=%0d got=%b exp=%b", c, imemREN, e_ren); end
      checks++; if (pc_next !== e_pcn) begin errors++; $display("FAIL rnd_pc_next cyc=%0d got=%b exp=%b", c, pc_next, e_pcn); end
      checks++; if (instr_valid !== e_vld) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, instr_valid, e_vld); end
      if (e_vld) begin
        checks++; if ({instr, instr_pc} !== e_head) begin errors++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", c, instr, instr_pc, e_head.ins, e_head.pc); end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
    advance();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    advance();
    ihit = 1'b1; redirect = 1'b1;
    #2 nRST = 1'b0;
    #1;
    checks++; if (imemREN !== 1'b0 || pc_next !== 1'b0) begin
      errors++; $display("FAIL arst_outputs got=%b/%b exp=0/0", imemREN, pc_next); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", instr_valid); end
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (pc_next !== e_pcn) begin errors++; $display("FAIL arst_pc_next cyc=%0d got=%b exp=%b", c, pc_next, e_pcn); end
      if (e_vld) begin
        checks++; if ({instr, instr_pc} !== e_head) begin errors++; $display("FAIL arst_head cyc=%0d got=%h exp=%h", c, instr_pc, e_head.pc); end
      end
      advance();
    end
  endtask

  task automatic test_halt();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    advance();
    repeat (2) begin apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); advance(); end
    apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    checks++; if (imemREN !== 1'b0 || pc_next !== 1'b0) begin
      errors++; $display("FAIL halt_same_cycle got=%b/%b exp=0/0", imemREN, pc_next); end
    advance();
    for (int c = 0; c < 6; c++) begin
      apply(1'b1, 1'b1, c % 2 == 0, 1'b0, 32'h200);
      checks++; if (pc_next !== 1'b0 || imemREN !== 1'b0) begin
        errors++; $display("FAIL halt_no_fetch cyc=%0d got=%b/%b exp=0/0", c, pc_next, imemREN); end
      checks++; if (instr_valid !== e_vld) begin errors++; $display("FAIL halt_valid cyc=%0d got=%b exp=%b", c, instr_valid, e_vld); end
      if (c == 0) begin
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL halt_drain0 got=%h exp=100", instr_pc); end
      end
      if (c == 1) begin
        checks++; if (instr_pc !== 32'h104) begin errors++; $display("FAIL halt_drain1 got=%h exp=104", instr_pc); end
      end
      advance();
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    nRST = 1'b0;
    #1;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    advance();
    for (int c = 0; c < 10; c++) begin
      apply(c % 2 == 1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (fetch_count !== m_fetch || stall_count !== m_stall) begin
        errors++; $display("FAIL stats_track cyc=%0d got=%0d/%0d exp=%0d/%0d", c, fetch_count, stall_count, m_fetch, m_stall); end
      advance();
    end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL stats_fetch got=%0d exp=5", fetch_count); end
    checks++; if (stall_count !== 32'd5) begin errors++; $display("FAIL stats_stall got=%0d exp=5", stall_count); end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 nRST = 1'b0;
    #1;
    checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL stats_reset got=%0d/%0d/%b exp=0/0/0", fetch_count, stall_count, instr_valid); end
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_backpressure();
    test_redirect();
    test_random();
    test_async_reset();
    test_halt();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program counter interface: takes the current instruction address, fetches from instruction memory, and pulses the PC-advance enable once each fetch completes.
- Buffers fetched words with their addresses in a small in-order queue feeding decode, so an imem wait or a decode stall does not leave the PC misaligned.
- Sits between program_counter, the instruction-memory port and the decode stage.

Parameters:
- QDEPTH, 2, instruction queue entries (power of two, 2..8)

Ports:
- CLK  input  1  clock, rising-edge
- nRST  input  1  reset, asynchronous, active-low
- i_addr  input  32  current PC from program counter
- pc_next  output  1  PC update enable to program counter
- redirect  input  1  jump/branch/jr resolved taken this cycle; PC source already selected upstream
- halt  input  1  stop fetching
- imemREN  output  1  instruction memory read enable
- imemaddr  output  32  instruction memory address
- ihit  input  1  memory returns data this cycle
- imemload  input  32  instruction data
- instr  output  32  head-of-queue instruction
- instr_pc  output  32  address of instr
- instr_valid  output  1  queue non-empty
- instr_ready  input  1  decode accepts head this cycle

Behaviour:
- State machine: IDLE, FETCH, HALTED.
  - Reset → IDLE.
  - IDLE → FETCH on the first clock edge.
  - FETCH → HALTED on halt=1.
  - HALTED is held until reset.
- Reset values: queue empty, instr_valid=0, instr=0, instr_pc=0, pc_next=0, imemREN=0.
- imemaddr = i_addr at all times (combinational).
- imemREN = (state==FETCH) && !full && !halt.
- Accept condition, all in the same cycle: imemREN && ihit && !redirect.
  - Push {imemload, i_addr} into the queue.
  - Assert pc_next=1 combinationally.
  - The PC advances on the next edge; the next request uses the new address.
  - Zero-wait-state memory therefore gives 1 instruction/cycle.
- redirect=1 (state FETCH or IDLE):
  - pc_next=1.
  - Any ihit data this cycle is discarded.
  - Queue is flushed at the next edge; instr_valid=0 the following cycle.
  - A pop in the same cycle is ignored; no double count.
- redirect has priority over accept, pop and full.
- Pop: instr_valid && instr_ready && !redirect removes the head at the edge.
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- Full (count==QDEPTH):
  - imemREN=0 and pc_next=0.
  - A pop this cycle does not enable a push until the next cycle; imemREN is derived from the registered count.
- Empty: instr_valid=0; instr/instr_pc hold their last values (don't-care).
- Queue pointers wrap modulo QDEPTH; count width is clog2(QDEPTH)+1.
- halt:
  - imemREN and pc_next are forced 0 in the same cycle.
  - Already-queued entries still drain to decode.
  - redirect is ignored in HALTED.
- Asynchronous nRST mid-fetch: queue cleared immediately; pc_next/imemREN drop to 0 combinationally.

Optional Feature:
- Macro: FETCH_STATS_EN.
- With it defined, extra output ports:
  - fetch_count[31:0]: increments on each accepted push.
  - stall_count[31:0]: increments each FETCH cycle with imemREN=1 and ihit=0, or with full=1.
  - Both reset to 0 and wrap at 2^32.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, ihit tied 1, instr_ready=1, PC model +4 from 0 → pc_next high every cycle after IDLE; instr_pc sequence 0x0,0x4,0x8; instr matches memory image.
- ihit delayed 3 cycles per fetch → pc_next single-cycle pulses only on ihit cycles; i_addr steady during wait; imemREN held.
- instr_ready=0, ihit=1, QDEPTH=2 → exactly 2 pushes (0x0,0x4); then imemREN=0, pc_next=0; instr_ready=1 for one cycle → head 0x4; one more fetch of 0x8 next cycle.
- Queue holding 0x10,0x14; redirect=1 with ihit=1 and PC jump target 0x400 → pc_next=1, ihit data dropped, instr_valid=0 next cycle, next pushed instr_pc=0x400.
- halt=1 with 2 queued entries → imemREN=0 the same cycle, both entries still drain, no further pc_next; redirect ignored.
- FETCH_STATS_EN: 5 fetches at 1 wait state each → fetch_count=5, stall_count=5; nRST mid-run → both 0, queue empty.
